// File: rtl/hex_display_multi_if.sv
// Bus between a board-level top and the multi-digit hex display controller.
// The top drives value/mode/display controls; the controller returns segments and wrap.
interface hex_display_multi_if #(
   parameter int DIGITS = 6
);
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [1:0]            mode;
   logic                  blank_lz;
   logic                  blink;
   logic [7*DIGITS-1:0]   hex;
   logic                  wrap;

   modport master (output load, data, mode, blank_lz, blink, input hex, wrap);
   modport slave  (input load, data, mode, blank_lz, blink, output hex, wrap);
endinterface

// File: rtl/hex_display_multi.sv
// Multi-digit seven-segment controller: value register with load/up/down counting,
// registered active-low decode, leading-zero blanking, blinking. Define HEX_DISP_DECIMAL_EN for BCD counting.
module hex_display_multi #(
   parameter int DIGITS    = 6,
   parameter int TICK_DIV  = 50000000,
   parameter int BLINK_DIV = 12500000
) (
   input  logic                clk,
   input  logic                reset,
   hex_display_multi_if.slave  bus
);
   localparam int VW = 4*DIGITS;
   localparam int HW = 7*DIGITS;
   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_DIV);
`ifdef HEX_DISP_DECIMAL_EN
   localparam logic [VW-1:0] MAX_VAL = {DIGITS{4'h9}};
`else
   localparam logic [VW-1:0] MAX_VAL = '1;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   function automatic logic [VW-1:0] sat_load(input logic [VW-1:0] v);
`ifdef HEX_DISP_DECIMAL_EN
      logic [VW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
`else
      return v;
`endif
   endfunction

   function automatic logic [VW-1:0] inc_val(input logic [VW-1:0] v);
`ifdef HEX_DISP_DECIMAL_EN
      logic [VW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
`else
      return v + VW'(1);
`endif
   endfunction

   function automatic logic [VW-1:0] dec_val(input logic [VW-1:0] v);
`ifdef HEX_DISP_DECIMAL_EN
      logic [VW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
`else
      return v - VW'(1);
`endif
   endfunction

   logic [VW-1:0] val_p0;
   logic          wrap_p0;
   logic [HW-1:0] hex_p1;
   logic [TW-1:0] tick_cnt;
   logic [BW-1:0] blink_cnt;
   logic          phase_on;

   logic          counting;
   logic          tick;
   logic [VW-1:0] val_nxt;
   logic          wrap_nxt;
   logic          show;
   logic          lead;
   logic [HW-1:0] hex_nxt;

   always_comb begin
      counting = (bus.mode == 2'b01) || (bus.mode == 2'b10);
      tick     = counting && (tick_cnt == TW'(TICK_DIV-1));
      val_nxt  = val_p0;
      wrap_nxt = 1'b0;
      if (bus.load) begin
         val_nxt = sat_load(bus.data);
      end else if (tick) begin
         if (bus.mode == 2'b01) begin
            val_nxt  = inc_val(val_p0);
            wrap_nxt = (val_p0 == MAX_VAL);
         end else begin
            val_nxt  = dec_val(val_p0);
            wrap_nxt = (val_p0 == '0);
         end
      end
   end

   // Stage p0: value register, wrap flag, tick and blink timebases
   always_ff @(posedge clk) begin
      if (reset) begin
         val_p0   <= '0;
         wrap_p0  <= 1'b0;
         tick_cnt <= '0;
      end else begin
         val_p0  <= val_nxt;
         wrap_p0 <= wrap_nxt;
         if (bus.load || !counting || tick) tick_cnt <= '0;
         else                               tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !bus.blink) begin
         blink_cnt <= '0;
         phase_on  <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV-1)) begin
         blink_cnt <= '0;
         phase_on  <= ~phase_on;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Dropping blink must relight the display on the very next edge, so the phase is overridden here
   always_comb begin
      show    = phase_on || !bus.blink;
      hex_nxt = '1;
      lead    = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         lead = lead && (val_p0[4*i +: 4] == 4'h0);
         if (show && !(bus.blank_lz && lead && (i != 0)))
            hex_nxt[7*i +: 7] = seg7(val_p0[4*i +: 4]);
      end
   end

   // Stage p1: registered segment outputs
   always_ff @(posedge clk) begin
      if (reset) hex_p1 <= '1;
      else       hex_p1 <= hex_nxt;
   end

   assign bus.hex  = hex_p1;
   assign bus.wrap = wrap_p0;
endmodule

// File: tb/tb_hex_display_multi.sv
// Directed bench for hex_display_multi: a 6-digit instance for reset/decode and a
// 2-digit instance (TICK_DIV=4, BLINK_DIV=3) for load, counting, collision, freeze and blink.
module tb_hex_display_multi;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

`ifdef HEX_DISP_DECIMAL_EN
   localparam logic [7:0] UP_START = 8'h98;
   localparam logic [6:0] SEG_A    = 7'h10;
   localparam logic [6:0] SEG_TOP  = 7'h10;
`else
   localparam logic [7:0] UP_START = 8'hFE;
   localparam logic [6:0] SEG_A    = 7'h08;
   localparam logic [6:0] SEG_TOP  = 7'h0E;
`endif

   hex_display_multi_if #(.DIGITS(6)) i6 ();
   hex_display_multi_if #(.DIGITS(2)) i2 ();

   hex_display_multi #(.DIGITS(6), .TICK_DIV(4), .BLINK_DIV(3)) u6 (
      .clk(clk), .reset(reset), .bus(i6.slave));
   hex_display_multi #(.DIGITS(2), .TICK_DIV(4), .BLINK_DIV(3)) u2 (
      .clk(clk), .reset(reset), .bus(i2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [13:0] shown;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      i6.load = 1'b0; i6.data = '0; i6.mode = 2'b00; i6.blank_lz = 1'b0; i6.blink = 1'b0;
      i2.load = 1'b0; i2.data = '0; i2.mode = 2'b00; i2.blank_lz = 1'b0; i2.blink = 1'b0;

      // reset
      step(2);
      chk("rst_hex6", 64'(i6.hex), 64'({42{1'b1}}));
      chk("rst_wrap6", 64'(i6.wrap), 64'(0));
      chk("rst_hex2", 64'(i2.hex), 64'(14'h3FFF));
      reset = 1'b0;
      step(1);
      chk("rel_hex6", 64'(i6.hex), 64'({6{7'h40}}));
      chk("rel_hex2", 64'(i2.hex), 64'({7'h40, 7'h40}));

      // load 0A with leading-zero blanking
      i2.blank_lz = 1'b1; i2.data = 8'h0A; i2.load = 1'b1;
      step(1);
      i2.load = 1'b0;
      chk("load_lat1", 64'(i2.hex), 64'({7'h7F, 7'h40}));
      step(1);
      chk("load_blank", 64'(i2.hex), 64'({7'h7F, SEG_A}));
      i2.blank_lz = 1'b0;
      step(1);
      chk("load_noblank", 64'(i2.hex), 64'({7'h40, SEG_A}));

      // count up through wrap
      i2.data = UP_START; i2.load = 1'b1;
      step(1);
      i2.load = 1'b0; i2.mode = 2'b01;
      step(4);
      chk("up_wrap_idle", 64'(i2.wrap), 64'(0));
      step(1);
      chk("up_top", 64'(i2.hex), 64'({SEG_TOP, SEG_TOP}));
      step(3);
      chk("up_wrap", 64'(i2.wrap), 64'(1));
      step(1);
      chk("up_wrap_end", 64'(i2.wrap), 64'(0));
      chk("up_zero", 64'(i2.hex), 64'({7'h40, 7'h40}));

      // count down from 0, then load colliding with a tick
      i2.data = 8'h00; i2.load = 1'b1; i2.mode = 2'b10;
      step(1);
      i2.load = 1'b0;
      step(4);
      chk("dn_wrap", 64'(i2.wrap), 64'(1));
      step(1);
      chk("dn_top", 64'(i2.hex), 64'({SEG_TOP, SEG_TOP}));
      chk("dn_wrap_end", 64'(i2.wrap), 64'(0));
      step(2);
      i2.data = 8'h55; i2.load = 1'b1;
      step(1);
      i2.load = 1'b0;
      chk("coll_wrap", 64'(i2.wrap), 64'(0));
      step(1);
      chk("coll_55", 64'(i2.hex), 64'({7'h12, 7'h12}));
      step(3);
      chk("coll_hold", 64'(i2.hex), 64'({7'h12, 7'h12}));
      step(1);
      chk("coll_54", 64'(i2.hex), 64'({7'h12, 7'h19}));

      // freeze mid-period, resume with a fresh tick period
      i2.data = 8'h10; i2.load = 1'b1; i2.mode = 2'b01;
      step(1);
      i2.load = 1'b0;
      step(2);
      i2.mode = 2'b11;
      step(6);
      chk("frz_hold", 64'(i2.hex), 64'({7'h79, 7'h40}));
      chk("frz_wrap", 64'(i2.wrap), 64'(0));
      i2.mode = 2'b01;
      step(3);
      chk("res_early", 64'(i2.hex), 64'({7'h79, 7'h40}));
      step(1);
      chk("res_hold", 64'(i2.hex), 64'({7'h79, 7'h40}));
      step(1);
      chk("res_inc", 64'(i2.hex), 64'({7'h79, 7'h79}));

      // reset pulse while counting
      reset = 1'b1;
      step(1);
      chk("mrst_hex2", 64'(i2.hex), 64'(14'h3FFF));
      chk("mrst_wrap", 64'(i2.wrap), 64'(0));
      chk("mrst_hex6", 64'(i6.hex), 64'({42{1'b1}}));
      reset = 1'b0;
      step(1);
      chk("mrst_zero", 64'(i2.hex), 64'({7'h40, 7'h40}));
      step(3);
      chk("mrst_hold", 64'(i2.hex), 64'({7'h40, 7'h40}));
      step(1);
      chk("mrst_one", 64'(i2.hex), 64'({7'h40, 7'h79}));

      // blink with value 01: 3 cycles shown, 3 dark
      shown = {7'h40, 7'h79};
      i2.mode = 2'b00; i2.blink = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk($sformatf("blink_%0d", k), 64'(i2.hex), ((k % 6) < 3) ? 64'(shown) : 64'(14'h3FFF));
      end
      i2.blink = 1'b0;
      step(1);
      chk("blink_off", 64'(i2.hex), 64'(shown));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hex_display_multi.md
Name: hex_display_multi

Overview:
- Parametrised multi-digit seven-segment display controller for the DE10 Lite HEX5..HEX0 displays.
- Holds a DIGITS-wide hex value in a register. The value can be loaded, or counted up/down at a programmable tick rate.
- Per-digit outputs are registered and active-low. Leading-zero blanking and whole-display blinking are supported.
- Sits between board-level top modules (switch/key inputs) and the HEX pins, replacing the single-digit combinational decoder.

Parameters:
- DIGITS, 6, number of hex digits driven (1..8).
- TICK_DIV, 50000000, clk cycles per count tick (1 s at 50 MHz); must be >= 2.
- BLINK_DIV, 12500000, clk cycles per blink phase toggle; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  when 1, data is captured into the value register.
- data  in  4*DIGITS  value to load; nibble i goes to digit i (digit 0 = LSB = HEX0).
- mode  in  2  00 static, 01 count up, 10 count down, 11 freeze.
- blank_lz  in  1  when 1, leading zeros are blanked.
- blink  in  1  when 1, the whole display blinks.
- hex  out  7*DIGITS  active-low segments; digit i at bits [7i+6:7i], bit0=a .. bit6=g.
- wrap  out  1  one-cycle pulse on count wrap-around.

Behaviour:
- Reset (clk edge with reset=1):
  - VAL=0, tick_cnt=0, blink_cnt=0, blink phase=ON, wrap=0.
  - hex = all ones (all digits dark).
  - Reset takes priority over every other input.
- Value register VAL (4*DIGITS bits). Next-state priority: reset > load > tick > hold.
  - load=1: VAL<=data next edge. A tick coinciding with load is discarded; tick_cnt is cleared.
  - Tick generation:
    - tick_cnt counts 0..TICK_DIV-1 only in modes 01/10. tick=1 in the cycle where tick_cnt==TICK_DIV-1; tick_cnt then returns to 0.
    - In modes 00/11, tick_cnt is held at 0.
  - mode 01 on tick: VAL<=VAL+1 mod 16^DIGITS.
  - mode 10 on tick: VAL<=VAL-1 mod 16^DIGITS.
  - wrap=1 for the single cycle after VAL goes all-F->0 (up) or 0->all-F (down); otherwise 0.
  - mode 00 and 11 both hold VAL. The difference: a mode change 11->01/10 resumes with tick_cnt from 0.
- Decode, active-low, hex values:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Leading-zero blanking (blank_lz=1):
  - Digit i is dark (7F) if all nibbles j>=i are 0 and i>0.
  - Digit 0 is always shown.
- Blinking:
  - blink=1: blink_cnt counts 0..BLINK_DIV-1 and toggles the phase at wrap. While the phase is OFF, all digits are 7F.
  - blink=0: blink_cnt=0, phase forced ON.
  - Blinking does not affect VAL or counting.
- Latency:
  - hex is a register driven from VAL plus the current blank_lz and blink phase.
  - load/tick -> VAL: 1 cycle. VAL -> hex: 1 cycle. Total load-to-display latency: 2 cycles.
  - blank_lz change is visible on hex after 1 cycle.
- Reset mid-count clears VAL and counters immediately; counting resumes from 0 after reset is released if mode is 01/10.

Optional Feature:
- Macro HEX_DISP_DECIMAL_EN.
- Defined:
  - Counting is BCD per digit. Up counting goes 9->0 with carry to the next digit; down counting goes 0->9 with borrow.
  - Wrap occurs at 99..9 <-> 0.
  - On load, any nibble >9 is clamped to 9.
  - Decode is unchanged.
- Undefined: pure binary hex counting, no clamping.

Test Plan:
- Reset, DIGITS=6: reset=1 for 2 cycles -> hex=all ones, wrap=0. One cycle after release, blank_lz=0 -> every digit = 40.
- Load, DIGITS=2, blank_lz=1: data=8'h0A, load 1 cycle -> 2 cycles later hex[6:0]=08, hex[13:7]=7F. With blank_lz=0 -> hex[13:7]=40.
- Count up, TICK_DIV=4, DIGITS=2, VAL=8'hFE, mode=01:
  - Ticks every 4 cycles; VAL goes FE->FF->00.
  - wrap pulses exactly 1 cycle with VAL=00, hex = 40/40.
  - Macro defined: VAL=8'h98 -> 99 -> 00 with wrap.
- Count down with collision, TICK_DIV=4, mode=10, VAL=8'h00:
  - First tick -> FF and wrap=1.
  - Assert load (data=8'h55) on a tick cycle -> VAL=55 (tick lost); next decrement after 4 further cycles -> 54.
- Blink, BLINK_DIV=3, VAL=1:
  - blink=1 -> display alternates 3 cycles shown / 3 cycles all 7F.
  - Deassert blink during the OFF phase -> display shown again after 1 cycle.
- Freeze and mid-op reset, TICK_DIV=4:
  - mode 01 -> 11 mid-period holds VAL, no wrap.
  - Return to 01 -> first increment after 4 cycles.
  - reset pulse during counting -> VAL=0, hex dark for the reset cycle.
